// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite transfer/burst/size encodings and arbiter states shared by the bus arbiter
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } Transfer_state;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } Burst_state;

    typedef enum logic [1:0] {
        BYTE     = 2'd0,
        HALFWORD = 2'd1,
        WORD     = 2'd2,
        DWORD    = 2'd3
    } Size_state;

    typedef enum logic [1:0] {
        PARK   = 2'd0,
        OWNED  = 2'd1,
        LOCKED = 2'd2
    } Arb_state;

    // Beats still to come after the NONSEQ of a fixed-length burst; 0 for SINGLE and INCR
    function automatic logic [3:0] burst_beats(Burst_state b);
        return (b == WRAP16 || b == INCR16) ? 4'd15 :
               (b == WRAP8  || b == INCR8)  ? 4'd7  :
               (b == WRAP4  || b == INCR4)  ? 4'd3  : 4'd0;
    endfunction

endpackage

// File: rtl/ahb_arb_fsm.sv
// ahb_arb_fsm: grant state machine and burst beat counter; AHB_ARB_ROUND_ROBIN_EN selects round-robin ties (default: master 0 wins)
module ahb_arb_fsm
    import ahb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       hready_i,
    input  logic       hresp_i,
    input  logic [1:0] htrans_i,
    input  logic [2:0] hburst_i,
    output logic       owner_o
);

    Arb_state      state_q, state_d;
    logic          owner_q, owner_d;
    logic [3:0]    beats_left_q, beats_left_d;
    logic          incr_q, incr_d;
    logic          tie_win;
    logic          lock_start;
    logic          arb_point;
    logic          pick;
    Transfer_state trans;
    Burst_state    burst;

    assign trans = Transfer_state'(htrans_i);
    assign burst = Burst_state'(hburst_i);

    // An accepted NONSEQ that opens a locked burst keeps the current owner even on an otherwise free edge
    assign lock_start = hready_i && !hresp_i && trans == NONSEQ &&
                        (burst_beats(burst) != 4'd0 || burst == INCR);
    assign arb_point  = hready_i && state_q != LOCKED && !lock_start;
    assign pick       = (req_i == 2'b11) ? tie_win : req_i[1];

`ifdef AHB_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    assign tie_win      = ~last_grant_q;
    assign last_grant_d = (arb_point && req_i != 2'b00) ? pick : last_grant_q;

    // Remember who was granted last on a request so the other master wins the next tie
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last_grant_q <= 1'b1;
        else         last_grant_q <= last_grant_d;
    end
`else
    assign tie_win = 1'b0;
`endif

    // Next state: wait states freeze everything, an error response drops the burst, grants move only at arbitration points
    always_comb begin
        beats_left_d = beats_left_q;
        incr_d       = incr_q;
        owner_d      = owner_q;
        state_d      = state_q;
        if (hresp_i) begin
            beats_left_d = 4'd0;
            incr_d       = 1'b0;
        end else if (hready_i) begin
            beats_left_d = (trans == NONSEQ) ? burst_beats(burst) :
                           (trans == SEQ && beats_left_q != 4'd0) ? beats_left_q - 4'd1 : beats_left_q;
            incr_d       = (trans == NONSEQ) ? (burst == INCR) :
                           ((trans == SEQ || trans == BUSY) && incr_q);
        end
        if (arb_point) owner_d = pick;
        if (hready_i || hresp_i)
            state_d = (beats_left_d != 4'd0 || incr_d) ? LOCKED :
                      (req_i == 2'b00 && !owner_d)     ? PARK   : OWNED;
    end

    // Grant owner, burst counter, INCR-burst flag and state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= PARK;
            owner_q      <= 1'b0;
            beats_left_q <= 4'd0;
            incr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            beats_left_q <= beats_left_d;
            incr_q       <= incr_d;
        end
    end

    assign owner_o = owner_q;

endmodule

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: two-master AHB-Lite arbiter with address/data muxing; define AHB_ARB_ROUND_ROBIN_EN for round-robin ties
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  M0_HBUSREQ,
    input  logic                  M1_HBUSREQ,
    input  logic [ADDR_WIDTH-1:0] M0_HADDR,
    input  logic [ADDR_WIDTH-1:0] M1_HADDR,
    input  logic [1:0]            M0_HTRANS,
    input  logic [1:0]            M1_HTRANS,
    input  logic                  M0_HWRITE,
    input  logic                  M1_HWRITE,
    input  logic [1:0]            M0_HSIZE,
    input  logic [1:0]            M1_HSIZE,
    input  logic [2:0]            M0_HBURST,
    input  logic [2:0]            M1_HBURST,
    input  logic [DATA_WIDTH-1:0] M0_HWDATA,
    input  logic [DATA_WIDTH-1:0] M1_HWDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    output logic                  M0_HGRANT,
    output logic                  M1_HGRANT,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [1:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [DATA_WIDTH-1:0] HWDATA,
    output logic                  HMASTER
);

    logic addr_owner;
    logic data_owner_q, data_owner_d;

    ahb_arb_fsm u_fsm (
        .clk_i    (HCLK),
        .rst_ni   (HRESETn),
        .req_i    ({M1_HBUSREQ, M0_HBUSREQ}),
        .hready_i (HREADY),
        .hresp_i  (HRESP),
        .htrans_i (HTRANS),
        .hburst_i (HBURST),
        .owner_o  (addr_owner)
    );

    assign M0_HGRANT = !addr_owner;
    assign M1_HGRANT = addr_owner;

    // Address phase comes straight from the grant holder, with no pipeline stage
    assign HADDR  = addr_owner ? M1_HADDR  : M0_HADDR;
    assign HTRANS = addr_owner ? M1_HTRANS : M0_HTRANS;
    assign HWRITE = addr_owner ? M1_HWRITE : M0_HWRITE;
    assign HSIZE  = addr_owner ? M1_HSIZE  : M0_HSIZE;
    assign HBURST = addr_owner ? M1_HBURST : M0_HBURST;

    assign data_owner_d = HREADY ? addr_owner : data_owner_q;

    // Data-phase owner trails the address owner by one accepted transfer so a handover finishes the old data phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) data_owner_q <= 1'b0;
        else          data_owner_q <= data_owner_d;
    end

    assign HMASTER = data_owner_q;
    assign HWDATA  = data_owner_q ? M1_HWDATA : M0_HWDATA;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed scoreboard bench for the two-master AHB-Lite arbiter
module tb_ahb_bus_arbiter;
  import ahb_pkg::*;
  localparam int K_GNT   = 0;
  localparam int K_HM    = 1;
  localparam int K_ADDR  = 2;
  localparam int K_TR    = 3;
  localparam int K_WD    = 4;
  localparam int K_MEM   = 5;
  localparam int K_BEATS = 6;
`ifdef AHB_ARB_ROUND_ROBIN_EN
  localparam logic [31:0] SECOND_TIE = 32'd2;
`else
  localparam logic [31:0] SECOND_TIE = 32'd1;
`endif
  typedef struct {
    string       name;
    int          kind;
    logic [31:0] addr;
    logic [31:0] val;
  } exp_t;
  logic        HCLK, HRESETn;
  logic        M0_HBUSREQ, M1_HBUSREQ;
  logic [31:0] M0_HADDR, M1_HADDR;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE;
  logic [1:0]  M0_HSIZE, M1_HSIZE;
  logic [2:0]  M0_HBURST, M1_HBURST;
  logic [31:0] M0_HWDATA, M1_HWDATA;
  logic        HREADY, HRESP;
  logic        M0_HGRANT, M1_HGRANT;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [1:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HMASTER;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mon_act;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] mem [logic [31:0]];
  logic        pend_w;
  logic [31:0] pend_a;
  ahb_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .M0_HBUSREQ (M0_HBUSREQ),
    .M1_HBUSREQ (M1_HBUSREQ),
    .M0_HADDR   (M0_HADDR),
    .M1_HADDR   (M1_HADDR),
    .M0_HTRANS  (M0_HTRANS),
    .M1_HTRANS  (M1_HTRANS),
    .M0_HWRITE  (M0_HWRITE),
    .M1_HWRITE  (M1_HWRITE),
    .M0_HSIZE   (M0_HSIZE),
    .M1_HSIZE   (M1_HSIZE),
    .M0_HBURST  (M0_HBURST),
    .M1_HBURST  (M1_HBURST),
    .M0_HWDATA  (M0_HWDATA),
    .M1_HWDATA  (M1_HWDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .M0_HGRANT  (M0_HGRANT),
    .M1_HGRANT  (M1_HGRANT),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSIZE      (HSIZE),
    .HBURST     (HBURST),
    .HWDATA     (HWDATA),
    .HMASTER    (HMASTER)
  );
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_w = 1'b0;
      pend_a = 32'd0;
    end else if (HREADY) begin
      if (pend_w) mem[pend_a] = HWDATA;
      pend_w = HTRANS[1] && HWRITE;
      pend_a = HADDR;
    end
  end
  function automatic logic [31:0] actual(int k, logic [31:0] a);
    case (k)
      K_GNT:   return {30'd0, M1_HGRANT, M0_HGRANT};
      K_HM:    return {31'd0, HMASTER};
      K_ADDR:  return HADDR;
      K_TR:    return {30'd0, HTRANS};
      K_WD:    return HWDATA;
      K_MEM:   return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
      default: return {28'd0, dut.u_fsm.beats_left_q};
    endcase
  endfunction
  always @(negedge HCLK) begin
    while (sb.size() > 0) begin
      mon_e   = sb.pop_front();
      mon_act = actual(mon_e.kind, mon_e.addr);
      n_chk++;
      if (mon_act !== mon_e.val) begin
        n_fail++;
        $display("FAIL %s: actual 0x%0h required 0x%0h", mon_e.name, mon_act, mon_e.val);
      end
    end
  end
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask
  task automatic chk(input string n, input int k, input logic [31:0] v);
    sb.push_back('{name: n, kind: k, addr: 32'd0, val: v});
  endtask
  task automatic chk_mem(input string n, input logic [31:0] a, input logic [31:0] v);
    sb.push_back('{name: n, kind: K_MEM, addr: a, val: v});
  endtask
  task automatic m_addr(input int m, input logic [1:0] tr, input logic w, input logic [2:0] b, input logic [31:0] a);
    if (m == 0) begin
      M0_HTRANS = tr; M0_HWRITE = w; M0_HBURST = b; M0_HADDR = a;
    end else begin
      M1_HTRANS = tr; M1_HWRITE = w; M1_HBURST = b; M1_HADDR = a;
    end
  endtask
  task automatic idle_all();
    M0_HBUSREQ = 1'b0; M1_HBUSREQ = 1'b0;
    M0_HTRANS = IDLE;  M1_HTRANS = IDLE;
    M0_HWRITE = 1'b0;  M1_HWRITE = 1'b0;
    M0_HBURST = SINGLE; M1_HBURST = SINGLE;
    M0_HSIZE = WORD;   M1_HSIZE = WORD;
    HREADY = 1'b1;     HRESP = 1'b0;
  endtask
  initial begin
    HRESETn = 1'b0;
    idle_all();
    M0_HADDR = 32'h100; M1_HADDR = 32'h200;
    M0_HWDATA = 32'd0;  M1_HWDATA = 32'd0;
    tick();
    chk("rst_grant", K_GNT, 32'd1);
    chk("rst_hmaster", K_HM, 32'd0);
    chk("rst_haddr_m0", K_ADDR, 32'h100);
    chk("rst_beats", K_BEATS, 32'd0);
    tick();
    HRESETn = 1'b1;
    tick();
    M1_HBUSREQ = 1'b1;
    chk("s1_parked_grant", K_GNT, 32'd1);
    tick();
    m_addr(1, NONSEQ, 1'b1, SINGLE, 32'h0002_0000);
    chk("s1_m1_grant", K_GNT, 32'd2);
    chk("s1_haddr", K_ADDR, 32'h0002_0000);
    chk("s1_htrans", K_TR, 32'd2);
    chk("s1_hmaster_old", K_HM, 32'd0);
    tick();
    M1_HBUSREQ = 1'b0; M1_HTRANS = IDLE; M1_HWDATA = 32'h0000_000A;
    chk("s1_hmaster_m1", K_HM, 32'd1);
    chk("s1_hwdata", K_WD, 32'h0000_000A);
    chk("s1_grant_hold", K_GNT, 32'd2);
    tick();
    chk("s1_park", K_GNT, 32'd1);
    chk("s1_hmaster_trail", K_HM, 32'd1);
    chk_mem("s1_readback", 32'h0002_0000, 32'h0000_000A);
    tick();
    chk("s1_hmaster_back", K_HM, 32'd0);
    tick();
    M0_HBUSREQ = 1'b1;
    m_addr(0, NONSEQ, 1'b1, INCR4, 32'h0002_0008);
    chk("s2_grant_b1", K_GNT, 32'd1);
    chk("s2_haddr_b1", K_ADDR, 32'h0002_0008);
    for (int i = 1; i < 4; i++) begin
      tick();
      M1_HBUSREQ = 1'b1;
      m_addr(0, SEQ, 1'b1, INCR4, 32'h0002_0008 + 32'(4 * i));
      M0_HWDATA = 32'h0000_000C + 32'(16 * (i - 1));
      chk($sformatf("s2_grant_b%0d", i + 1), K_GNT, 32'd1);
      chk($sformatf("s2_hwdata_%0d", i), K_WD, 32'h0000_000C + 32'(16 * (i - 1)));
    end
    tick();
    M0_HBUSREQ = 1'b0; M0_HTRANS = IDLE; M0_HWDATA = 32'h0000_003C;
    chk("s2_grant_last", K_GNT, 32'd1);
    chk("s2_hwdata_4", K_WD, 32'h0000_003C);
    chk("s2_hmaster_m0", K_HM, 32'd0);
    tick();
    M1_HBUSREQ = 1'b0;
    chk("s2_grant_m1", K_GNT, 32'd2);
    chk_mem("s2_mem_first", 32'h0002_0008, 32'h0000_000C);
    chk_mem("s2_mem_last", 32'h0002_0014, 32'h0000_003C);
    tick();
    M0_HBUSREQ = 1'b1; M1_HBUSREQ = 1'b1;
    chk("s3_idle_a", K_GNT, 32'd1);
    tick();
    M0_HBUSREQ = 1'b0; M1_HBUSREQ = 1'b0;
    chk("s3_tie_1", K_GNT, 32'd1);
    tick();
    M0_HBUSREQ = 1'b1; M1_HBUSREQ = 1'b1;
    chk("s3_idle_b", K_GNT, 32'd1);
    tick();
    M0_HBUSREQ = 1'b0; M1_HBUSREQ = 1'b0;
    chk("s3_tie_2", K_GNT, SECOND_TIE);
    tick();
    chk("s3_park", K_GNT, 32'd1);
    tick();
    M1_HBUSREQ = 1'b1;
    chk("s4_req", K_GNT, 32'd1);
    tick();
    M0_HBUSREQ = 1'b1;
    m_addr(1, NONSEQ, 1'b0, WRAP4, 32'h0002_0000);
    chk("s4_m1_grant", K_GNT, 32'd2);
    tick();
    m_addr(1, SEQ, 1'b0, WRAP4, 32'h0002_0004);
    chk("s4_beats", K_BEATS, 32'd3);
    chk("s4_locked", K_GNT, 32'd2);
    tick();
    HRESP = 1'b1; HREADY = 1'b0;
    m_addr(1, SEQ, 1'b0, WRAP4, 32'h0002_0008);
    chk("s4_err1_grant", K_GNT, 32'd2);
    tick();
    HREADY = 1'b1;
    M1_HTRANS = IDLE;
    chk("s4_err_beats", K_BEATS, 32'd0);
    chk("s4_err2_grant", K_GNT, 32'd2);
    tick();
    HRESP = 1'b0;
    M0_HBUSREQ = 1'b0; M1_HBUSREQ = 1'b0;
    chk("s4_to_m0", K_GNT, 32'd1);
    tick();
    M0_HBUSREQ = 1'b1;
    m_addr(0, NONSEQ, 1'b1, SINGLE, 32'h0002_0020);
    chk("s5_m0_grant", K_GNT, 32'd1);
    tick();
    M0_HBUSREQ = 1'b0; M0_HTRANS = IDLE; M0_HWDATA = 32'h0000_0055;
    M1_HBUSREQ = 1'b1; M1_HWDATA = 32'h0000_0099;
    for (int i = 0; i < 4; i++) begin
      HREADY = (i == 3);
      chk($sformatf("s5_grant_w%0d", i), K_GNT, 32'd1);
      chk($sformatf("s5_hmaster_w%0d", i), K_HM, 32'd0);
      chk($sformatf("s5_hwdata_w%0d", i), K_WD, 32'h0000_0055);
      if (i < 3) tick();
    end
    tick();
    m_addr(1, NONSEQ, 1'b1, SINGLE, 32'h0002_0030);
    chk("s5_grant_m1", K_GNT, 32'd2);
    chk("s5_hmaster_old", K_HM, 32'd0);
    chk("s5_hwdata_old", K_WD, 32'h0000_0055);
    chk("s5_haddr_m1", K_ADDR, 32'h0002_0030);
    chk_mem("s5_mem", 32'h0002_0020, 32'h0000_0055);
    tick();
    M1_HTRANS = IDLE;
    chk("s5_hmaster_new", K_HM, 32'd1);
    chk("s5_hwdata_new", K_WD, 32'h0000_0099);
    tick();
    m_addr(1, NONSEQ, 1'b1, INCR8, 32'h0002_0040);
    chk("s6_grant", K_GNT, 32'd2);
    tick();
    m_addr(1, SEQ, 1'b1, INCR8, 32'h0002_0044);
    tick();
    m_addr(1, SEQ, 1'b1, INCR8, 32'h0002_0048);
    chk("s6_beats", K_BEATS, 32'd6);
    chk("s6_locked", K_GNT, 32'd2);
    tick();
    M0_HADDR = 32'h0000_1234;
    HRESETn = 1'b0;
    chk("s6_rst_grant", K_GNT, 32'd1);
    chk("s6_rst_hmaster", K_HM, 32'd0);
    chk("s6_rst_beats", K_BEATS, 32'd0);
    chk("s6_rst_haddr", K_ADDR, 32'h0000_1234);
    tick();
    HRESETn = 1'b1;
    idle_all();
    chk("s6_after_grant", K_GNT, 32'd1);
    chk("s6_after_hmaster", K_HM, 32'd0);
    tick();
    tick();
    if (n_chk < 12) begin
      n_fail++;
      $display("FAIL check_count: actual %0d required at least 12", n_chk);
    end
    if (n_fail == 0) $display("PASS: all %0d checks passed", n_chk);
    else $display("FAIL: %0d of %0d checks failed", n_fail, n_chk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

Two-master AHB-Lite arbiter and address/data multiplexer placed in front of `AHB_wrapper`. It lets two bus masters share the single slave port, which covers the register file, GPIO and timer. The block grants the bus, keeps a fixed-length burst (INCR4/8/16, WRAP4/8/16) atomic, and steers the data phase to the master that owns it. It contains no address decoding; `AHB_wrapper` keeps its own slave selection.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of the address bus
- `DATA_WIDTH`, 32, width of the write-data bus

Ports:
- `HCLK`  in  1  bus clock; the only clock
- `HRESETn`  in  1  asynchronous, active-low reset
- `M0_HBUSREQ` / `M1_HBUSREQ`  in  1  bus request from master 0 / master 1
- `M0_HADDR` / `M1_HADDR`  in  ADDR_WIDTH  address from each master
- `M0_HTRANS` / `M1_HTRANS`  in  2  transfer type from each master
- `M0_HWRITE` / `M1_HWRITE`  in  1  write/read from each master
- `M0_HSIZE` / `M1_HSIZE`  in  2  transfer size from each master
- `M0_HBURST` / `M1_HBURST`  in  3  burst type from each master
- `M0_HWDATA` / `M1_HWDATA`  in  DATA_WIDTH  write data from each master
- `HREADY`  in  1  transfer-done from the slave; also fanned out to both masters
- `HRESP`  in  1  error response from the slave (1 = ERROR)
- `M0_HGRANT` / `M1_HGRANT`  out  1  registered grant to each master; exactly one is high at any time
- `HADDR`, `HTRANS`, `HWRITE`, `HSIZE`, `HBURST`  out  as the master inputs  address-phase signals, muxed from the address owner
- `HWDATA`  out  DATA_WIDTH  write data, muxed from the data-phase owner
- `HMASTER`  out  1  index of the data-phase owner

## Operation
- Ownership registers:
  - `addr_owner` selects the address mux and always equals the index of the high grant.
  - `data_owner` is loaded from `addr_owner` on every edge where `HREADY`=1. It drives the `HWDATA` mux and `HMASTER`.
- Burst counter `beats_left` (4 bits):
  - On an accepted NONSEQ it loads 3, 7 or 15 for the 4-, 8- and 16-beat bursts, and 0 for SINGLE or INCR.
  - It decrements on each accepted SEQ. An accepted transfer is any edge where `HREADY`=1.
  - BUSY beats do not decrement it.
- State machine:
  - PARK: grant sits on master 0 and nobody is requesting.
  - OWNED: the owner holds the bus and may issue transfers.
  - LOCKED: `beats_left`≠0, or an INCR burst is in progress (owner `HTRANS` is SEQ or BUSY after a NONSEQ with `HBURST`=INCR).
- Arbitration point: an edge where `HREADY`=1, the state is not LOCKED, and the owner's `HTRANS` is IDLE or it is the last burst beat (`beats_left`=0).
- Grant rules at an arbitration point:
  - No requests: go to PARK with the grant on master 0.
  - One requester: it gets the grant.
  - Both requesting: the winner is chosen per Configuration.
  - The current owner keeps the bus if it still requests and the other master does not.
- Between arbitration points both grants hold their value.
- Error handling:
  - On the first ERROR cycle (`HRESP`=1, `HREADY`=0), `beats_left` clears and LOCKED exits.
  - The next edge with `HREADY`=1 is an arbitration point.
- `HWDATA` keeps following `data_owner` through a handover, so the old master's last data phase completes.

## Timing
- Reset values:
  - `M0_HGRANT`=1, `M1_HGRANT`=0, `HMASTER`=0, state PARK, `beats_left`=0.
  - Muxed outputs follow master 0's inputs.
- Grant latency:
  - A request raised in cycle N while the bus is idle sees its grant high after edge N+1.
  - That master's NONSEQ appears on `HADDR`/`HTRANS` in the cycle it drives it while granted. There are no arbiter pipeline stages on the address path.
- Handover is overlapped:
  - During the handover cycle the new owner's address phase runs while `HMASTER` and `HWDATA` still belong to the old owner.
  - `HMASTER` switches one accepted cycle later.
- Wait states (`HREADY`=0) freeze the grants, `data_owner`, `beats_left` and the state.
- Asserting `HRESETn` mid-burst returns every register to its reset value immediately. The burst is dropped.

## Configuration
- `AHB_ARB_ROUND_ROBIN_EN` defined: when both masters request at an arbitration point, the master not granted most recently wins. A 1-bit `last_grant` register tracks this and resets to 1, so master 0 wins the first tie.
- `AHB_ARB_ROUND_ROBIN_EN` undefined: fixed priority, master 0 always wins ties, and there is no `last_grant` register.

## Structure
- Shared package `ahb_pkg` holds:
  - the `Transfer_state`, `Burst_state` and `Size_state` enums (same encodings as the bench);
  - a function `burst_beats(Burst_state)` returning 0/3/7/15.
- One sub-module, `ahb_arb_fsm`: state machine, `beats_left`, grant and `last_grant` registers.
- The top level holds the muxes and `data_owner`.

## Test plan
- Reset → `M0_HGRANT`=1, `M1_HGRANT`=0, `HMASTER`=0; then M1 requests alone → `M1_HGRANT`=1 after one edge, and M1's SINGLE write of 0x0000_000A to 0x0002_0000 reads back 0x0000_000A.
- M0 runs an INCR4 write at 0x0002_0008 while M1 requests from beat 2 → the grant stays on M0 for all 4 beats and moves to M1 on the edge after the last beat. `HWDATA` sequence is 0xC, 0x1C, 0x2C, 0x3C.
- Both request from idle, repeated twice → fixed build: M0, M0. Round-robin build: M0, M1.
- M1 runs a WRAP4 burst and the slave returns ERROR on beat 2 (`HRESP` high for 2 cycles, `HREADY` low then high) → burst aborted and the grant passes to waiting M0 at the following edge.
- Handover with `HREADY` held low 3 cycles → grants, `HMASTER` and `HWDATA` unchanged until `HREADY`=1.
- `HRESETn` pulsed low mid-INCR8 owned by M1 → immediately `M0_HGRANT`=1, `HMASTER`=0, `beats_left`=0.
